// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: multiplexed seven-segment scanner with dead-time and tear-free frames.
// Define SEVSEG_LZB_EN to enable leading-zero blanking.
module sevseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_PERIOD = 100_000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [5*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out
);
    localparam int CW = $clog2(SCAN_PERIOD);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_PERIOD - 1);
    localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [5*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [5*NUM_DIGITS-1:0] act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              cat_q, cat_d;
    logic                    dp_q, dp_d;
    logic                    frame_q, frame_d;

    logic                    cnt_wrap;
    logic                    boundary;
    logic [4:0]              cur_code;
    logic [NUM_DIGITS-1:0]   blank_mask;
`ifdef SEVSEG_LZB_EN
    logic                    lz_run;
`endif

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'h00:   s = 7'h40;
            5'h01:   s = 7'h79;
            5'h02:   s = 7'h24;
            5'h03:   s = 7'h30;
            5'h04:   s = 7'h19;
            5'h05:   s = 7'h12;
            5'h06:   s = 7'h02;
            5'h07:   s = 7'h78;
            5'h08:   s = 7'h00;
            5'h09:   s = 7'h10;
            5'h0A:   s = 7'h08;
            5'h0B:   s = 7'h03;
            5'h0C:   s = 7'h46;
            5'h0D:   s = 7'h21;
            5'h0E:   s = 7'h06;
            5'h0F:   s = 7'h0E;
            5'h10:   s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        boundary = cnt_wrap && (idx_q == IDX_LAST);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        pend_val_d = load_in ? val_in : pend_val_q;
        pend_dp_d  = load_in ? dp_in : pend_dp_q;
        // Active frame only changes at the frame boundary, from pre-load pending.
        act_val_d  = boundary ? pend_val_q : act_val_q;
        act_dp_d   = boundary ? pend_dp_q : act_dp_q;
        frame_d    = boundary;

        blank_mask = '0;
`ifdef SEVSEG_LZB_EN
        lz_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lz_run && act_val_q[5*k +: 5] == 5'h00 && !act_dp_q[k]) begin
                blank_mask[k] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
`endif

        cur_code = act_val_q[5*int'(idx_q) +: 5];
        an_d     = '1;
        cat_d    = 7'h7F;
        dp_d     = 1'b1;
        if (cnt_q >= DEAD_CNT) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            cat_d = blank_mask[idx_q] ? 7'h7F : seg_decode(cur_code);
            dp_d  = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= {NUM_DIGITS{5'h1F}};
            pend_dp_q  <= '0;
            act_val_q  <= {NUM_DIGITS{5'h1F}};
            act_dp_q   <= '0;
            an_q       <= '1;
            cat_q      <= 7'h7F;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            an_q       <= an_d;
            cat_q      <= cat_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign an_out    = an_q;
    assign cat_out   = cat_q;
    assign dp_out    = dp_q;
    assign frame_out = frame_q;
endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Scoreboard bench for sevseg_scan_ctrl: expected digit slots and frame pulses
// are queued by the stimulus and popped by an independent monitor.
module tb_sevseg_scan_ctrl;
    localparam int ND = 4;
    localparam int SP = 8;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        load_in = 1'b0;
    logic [19:0] val_in = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_out;

    always #5 clk = ~clk;

    sevseg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_PERIOD(SP),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst_in),
        .val_in   (val_in),
        .dp_in    (dp_in),
        .load_in  (load_in),
        .cat_out  (cat_out),
        .dp_out   (dp_out),
        .an_out   (an_out),
        .frame_out(frame_out)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [11:0] disp_q[$];
    int fo_q[$];
    int edge_n = 0;
    int cyc = 0;
    int rst_cnt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (rst_in) begin
            cyc <= 0;
            rst_cnt <= rst_cnt + 1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    logic [11:0] cur_exp = '0;
    logic        lit_prev = 1'b0;
    logic        lit_now;
    int          lit_len = 0;
    int          run_rst = 0;

    always @(negedge clk) begin
        lit_now = (an_out !== 4'hF);
        if (lit_now && !lit_prev) begin
            lit_len = 1;
            run_rst = rst_cnt;
            if (disp_q.size() == 0) begin
                n_total++;
                $display("FAIL disp_underflow: got an=%b with no slot expected at %0t",
                         an_out, $time);
            end else begin
                cur_exp = disp_q.pop_front();
                check("disp_first", {20'h0, an_out, cat_out, dp_out}, {20'h0, cur_exp});
            end
        end else if (lit_now) begin
            lit_len++;
            check("disp_hold", {20'h0, an_out, cat_out, dp_out}, {20'h0, cur_exp});
        end else if (lit_prev && run_rst == rst_cnt) begin
            check("lit_len", lit_len, SP - DC);
        end
        if (frame_out) begin
            if (fo_q.size() == 0) begin
                n_total++;
                $display("FAIL frame_unexp: got pulse at cyc %0d want none", cyc);
            end else begin
                check("frame_cyc", cyc, fo_q.pop_front());
            end
        end
        lit_prev = lit_now;
    end

    task automatic run_to(int n);
        while (edge_n < n) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
        end
    endtask

    task automatic load_at(int n, logic [19:0] v, logic [3:0] d);
        run_to(n - 1);
        val_in  = v;
        dp_in   = d;
        load_in = 1'b1;
        run_to(n);
        load_in = 1'b0;
    endtask

    task automatic push_frame(logic [6:0] c0, logic [6:0] c1, logic [6:0] c2,
                              logic [6:0] c3, logic [3:0] dpn);
        disp_q.push_back({4'b1110, c0, dpn[0]});
        disp_q.push_back({4'b1101, c1, dpn[1]});
        disp_q.push_back({4'b1011, c2, dpn[2]});
        disp_q.push_back({4'b0111, c3, dpn[3]});
    endtask

    task automatic check_blank(string tag);
        check({tag, "_an"}, {28'h0, an_out}, 32'hF);
        check({tag, "_cat"}, {25'h0, cat_out}, 32'h7F);
        check({tag, "_dp"}, {31'h0, dp_out}, 32'h1);
        check({tag, "_frame"}, {31'h0, frame_out}, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_blank("rst");
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        for (int f = 1; f <= 8; f++) fo_q.push_back(32 * f);
        rst_in = 1'b0;
        edge_n = 0;

        load_at(40, {5'h03, 5'h02, 5'h01, 5'h00}, 4'b0000);
        push_frame(7'h40, 7'h79, 7'h24, 7'h30, 4'b1111);
        load_at(70, {5'h10, 5'h1F, 5'h0A, 5'h0F}, 4'b0100);
        push_frame(7'h0E, 7'h08, 7'h7F, 7'h3F, 4'b1011);
        load_at(100, {5'h08, 5'h08, 5'h08, 5'h08}, 4'b1111);
        load_at(110, {5'h04, 5'h05, 5'h06, 5'h07}, 4'b0001);
        push_frame(7'h78, 7'h02, 7'h12, 7'h19, 4'b1110);
        load_at(128, {5'h09, 5'h0B, 5'h0C, 5'h0D}, 4'b0000);
        push_frame(7'h21, 7'h46, 7'h03, 7'h10, 4'b1111);
        load_at(170, {5'h00, 5'h00, 5'h00, 5'h07}, 4'b0000);
`ifdef SEVSEG_LZB_EN
        push_frame(7'h78, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
`else
        push_frame(7'h78, 7'h40, 7'h40, 7'h40, 4'b1111);
`endif
        load_at(200, {5'h00, 5'h00, 5'h00, 5'h00}, 4'b0000);
`ifdef SEVSEG_LZB_EN
        push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        disp_q.push_back({4'b1110, 7'h40, 1'b1});
        disp_q.push_back({4'b1101, 7'h7F, 1'b1});
        disp_q.push_back({4'b1011, 7'h7F, 1'b1});
`else
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
        disp_q.push_back({4'b1110, 7'h40, 1'b1});
        disp_q.push_back({4'b1101, 7'h40, 1'b1});
        disp_q.push_back({4'b1011, 7'h40, 1'b1});
`endif

        // Reset lands while digit 2 of the frame is lit.
        run_to(278);
        rst_in = 1'b1;
        run_to(279);
        rst_in = 1'b0;
        check_blank("midrst");
        edge_n = 0;
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        fo_q.push_back(32);
        fo_q.push_back(64);
        run_to(66);
        #1;
        check("disp_drained", disp_q.size(), 0);
        check("frame_drained", fo_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
